// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: parses a counted, XOR-checksummed byte frame,
// writes big-endian 32-bit words to the instruction memory and releases the CPU on success.
module im_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err
);
    localparam logic [1:0] S_CNT  = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CSUM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TIMEOUT_V = TW'(TIMEOUT);
    localparam logic [TW-1:0]   IDLE_ONE  = TW'(1);
    localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        acc_q, acc_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_waddr_q, im_waddr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;

    logic xfer;
    logic timeout_hit;

    assign xfer = in_valid && in_ready_q;
    assign timeout_hit = (TIMEOUT != 0) && !xfer
                         && ((state_q == S_DATA) || (state_q == S_CSUM))
                         && ((idle_q + IDLE_ONE) == TIMEOUT_V);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        im_we_d    = 1'b0;
        im_waddr_d = im_waddr_q;
        im_wdata_d = im_wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;

        if (xfer) begin
            idle_d = '0;
        end else if ((state_q == S_DATA) || (state_q == S_CSUM)) begin
            idle_d = idle_q + IDLE_ONE;
        end else begin
            idle_d = '0;
        end

        case (state_q)
            S_CNT: begin
                if (xfer) begin
                    // A zero count byte stands for a full memory image.
                    n_d     = (in_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(in_data);
                    idx_d   = '0;
                    bcnt_d  = 2'd0;
                    acc_d   = in_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    acc_d   = acc_q ^ in_data;
                    bcnt_d  = bcnt_q + 2'd1;
                    shift_d = {shift_q[15:0], in_data};
                    if (bcnt_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_waddr_d = idx_q[ADDR_W-1:0];
                        im_wdata_d = {shift_q, in_data};
                        idx_d      = idx_q + IDX_ONE;
                        if ((idx_q + IDX_ONE) == n_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    err_d      = 2'b10;
                    cpu_hold_d = 1'b1;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    err_d      = (in_data == acc_q) ? 2'b00 : 2'b01;
                    cpu_hold_d = (in_data != acc_q);
                end else if (timeout_hit) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    err_d      = 2'b10;
                    cpu_hold_d = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d    = S_CNT;
                    done_d     = 1'b0;
                    err_d      = 2'b00;
                    cpu_hold_d = 1'b1;
                end
            end
        endcase

        in_ready_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CNT;
            n_q        <= '0;
            idx_q      <= '0;
            bcnt_q     <= 2'd0;
            shift_q    <= '0;
            acc_q      <= '0;
            idle_q     <= '0;
            in_ready_q <= 1'b1;
            im_we_q    <= 1'b0;
            im_waddr_q <= '0;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            idle_q     <= idle_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_waddr_q <= im_waddr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_waddr = im_waddr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table of N=2 frames plus timeout, full-image and
// mid-word reset sequences; memory writes are checked against a queue of expected words.
module tb_im_loader;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        start;
    logic        im_we;
    logic [7:0]  im_waddr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic [1:0]  err;

    im_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .start(start), .im_we(im_we), .im_waddr(im_waddr),
        .im_wdata(im_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  flip;
        int          gaps;
        logic [1:0]  exp_err;
        logic        exp_hold;
    } vec_t;

    wr_t         exp_q[$];
    logic [31:0] frame_words[256];
    vec_t        vecs[4];
    int          checks;
    int          errors;
    int          write_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (im_we === 1'b1) begin
                write_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", im_waddr, im_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_output("write_addr", {24'd0, im_waddr}, {24'd0, e.addr});
                    check_output("write_data", im_wdata, e.data);
                end
            end
            if (done === 1'b0) check_output("in_ready_before_done", {31'd0, in_ready}, 32'd1);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic took;
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50; k++) begin
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_accept: got no transfer expected transfer of 0x%0h", b);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] count, input int nwords, input int data_limit,
                                  input logic [7:0] flip, input int gaps, input bit send_csum);
        logic [7:0] acc;
        logic [7:0] b;
        int         p[3];
        int         total;
        total = nwords * 4;
        for (int g = 0; g < 3; g++) p[g] = (gaps > g) ? int'($urandom_range(0, total - 1)) : -1;
        acc = count;
        send_byte(count);
        for (int i = 0; i < total && i < data_limit; i++) begin
            int idle;
            idle = 0;
            for (int g = 0; g < 3; g++) if (p[g] == i) idle++;
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
            b = frame_words[i / 4][31 - 8 * (i % 4) -: 8];
            acc = acc ^ b;
            if ((i % 4) == 3) exp_q.push_back('{addr: 8'(i / 4), data: frame_words[i / 4]});
            send_byte(b);
        end
        if (send_csum) begin
            check_output("done_before_csum", {31'd0, done}, 32'd0);
            check_output("hold_before_csum", {31'd0, cpu_hold}, 32'd1);
            send_byte(acc ^ flip);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("rearm_done", {31'd0, done}, 32'd0);
        check_output("rearm_err", {30'd0, err}, 32'd0);
        check_output("rearm_hold", {31'd0, cpu_hold}, 32'd1);
        check_output("rearm_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check_output({tag, "_im_we"}, {31'd0, im_we}, 32'd0);
        check_output({tag, "_im_waddr"}, {24'd0, im_waddr}, 32'd0);
        check_output({tag, "_im_wdata"}, im_wdata, 32'd0);
        check_output({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check_output({tag, "_done"}, {31'd0, done}, 32'd0);
        check_output({tag, "_err"}, {30'd0, err}, 32'd0);
    endtask

    initial begin
        int cycles;
        checks      = 0;
        errors      = 0;
        write_count = 0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        start       = 1'b0;
        rst_n       = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        vecs[0] = '{w0: 32'h2001000A, w1: 32'h8C220004, flip: 8'h00, gaps: 0, exp_err: 2'b00, exp_hold: 1'b0};
        vecs[1] = '{w0: 32'h2001000A, w1: 32'h8C220004, flip: 8'h01, gaps: 0, exp_err: 2'b01, exp_hold: 1'b1};
        vecs[2] = '{w0: 32'h2001000A, w1: 32'h8C220004, flip: 8'h00, gaps: 3, exp_err: 2'b00, exp_hold: 1'b0};
        vecs[3] = '{w0: 32'hDEADBEEF, w1: 32'h01234567, flip: 8'h80, gaps: 3, exp_err: 2'b01, exp_hold: 1'b1};

        for (int v = 0; v < 4; v++) begin
            frame_words[0] = vecs[v].w0;
            frame_words[1] = vecs[v].w1;
            apply_stimulus(8'd2, 2, 8, vecs[v].flip, vecs[v].gaps, 1'b1);
            check_output("frame_done", {31'd0, done}, 32'd1);
            check_output("frame_err", {30'd0, err}, {30'd0, vecs[v].exp_err});
            check_output("frame_hold", {31'd0, cpu_hold}, {31'd0, vecs[v].exp_hold});
            check_output("frame_ready_low", {31'd0, in_ready}, 32'd0);
            check_output("frame_writes_left", exp_q.size(), 32'd0);
            pulse_start();
        end

        // Stall after five data bytes: only word 0 lands, then the idle limit fires.
        frame_words[0] = 32'h11223344;
        frame_words[1] = 32'h55667788;
        apply_stimulus(8'd2, 2, 5, 8'h00, 0, 1'b0);
        cycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
        check_output("timeout_cycles", cycles, 32'd16);
        check_output("timeout_done", {31'd0, done}, 32'd1);
        check_output("timeout_err", {30'd0, err}, 32'd2);
        check_output("timeout_hold", {31'd0, cpu_hold}, 32'd1);
        check_output("timeout_writes_left", exp_q.size(), 32'd0);
        pulse_start();

        for (int i = 0; i < 256; i++) begin
            logic [7:0] x;
            x = 8'(i);
            frame_words[i] = {x, x ^ 8'hA5, ~x, 8'h3C};
        end
        write_count = 0;
        apply_stimulus(8'd0, 256, 1024, 8'h00, 0, 1'b1);
        check_output("full_write_count", write_count, 32'd256);
        check_output("full_writes_left", exp_q.size(), 32'd0);
        check_output("full_done", {31'd0, done}, 32'd1);
        check_output("full_err", {30'd0, err}, 32'd0);
        check_output("full_hold", {31'd0, cpu_hold}, 32'd0);
        pulse_start();

        send_byte(8'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midword");
        @(posedge clk);
        #1 rst_n = 1'b1;
        frame_words[0] = 32'hCAFEF00D;
        apply_stimulus(8'd1, 1, 4, 8'h00, 0, 1'b1);
        check_output("post_reset_done", {31'd0, done}, 32'd1);
        check_output("post_reset_err", {30'd0, err}, 32'd0);
        check_output("post_reset_hold", {31'd0, cpu_hold}, 32'd0);
        check_output("post_reset_writes_left", exp_q.size(), 32'd0);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/im_loader.md
# im_loader

Boot-time writer for the instruction memory. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory's write port one word per pulse. It holds the CPU in reset until a frame has loaded and its checksum has passed. It sits between the host link (UART receiver or testbench) and the instruction memory, and replaces file preload on hardware.

## Interface
- ADDR_W, 8, word-address width of the instruction memory (256 words).
- TIMEOUT, 1000000, idle-cycle limit inside a frame. 0 disables the timeout.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- start  input  1  single-cycle pulse; re-arms the loader from DONE.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_waddr  output  ADDR_W  word address for the write.
- im_wdata  output  32  instruction word for the write.
- cpu_hold  output  1  held high while the CPU must stay in reset.
- done  output  1  frame finished, with or without error.
- err  output  2  error code: 00 none, 01 checksum mismatch, 10 timeout.

## Operation
- Frame format: one count byte N, then N×4 data bytes, then one checksum byte.
  - N=0 means 2^ADDR_W words.
  - Each word is sent MSB first: byte0 goes to [31:24], byte3 to [7:0].
- A byte transfers only when in_valid and in_ready are both high at the clock edge.
- States:
  - CNT: in_ready=1. A transfer latches N, clears the word index and the checksum accumulator, then moves to DATA.
  - DATA: in_ready=1. A 2-bit byte counter and a 24-bit shift register assemble each word. On the 4th byte of a word, im_wdata gets {shift, in_data}, im_waddr gets the word index, and the index increments. When the index reaches N, the state moves to CSUM.
  - CSUM: in_ready=1. A transfer compares the byte with the accumulator and moves to DONE.
    - Match: err=00, cpu_hold=0.
    - Mismatch: err=01, cpu_hold stays 1.
  - DONE: in_ready=0, done=1. A start pulse clears done and err, sets cpu_hold=1, and moves to CNT. start is ignored in every other state.
- Checksum: running XOR of the count byte and all data bytes. The checksum byte itself is not included.
- Timeout: an idle counter clears on every transfer and on entry to CNT. It counts while the state is DATA or CSUM and no transfer occurs.
  - When the counter reaches TIMEOUT, the loader goes to DONE with err=10 and cpu_hold=1.
  - CNT never times out.
  - A partial frame leaves already-written words in memory.
- Memory content outside the index range 0..N-1 is never written.

## Timing
- Reset values:
  - state = CNT
  - in_ready = 1 (registered; it is 1 in CNT)
  - im_we = 0, im_waddr = 0, im_wdata = 0
  - cpu_hold = 1, done = 0, err = 00
- im_we is registered. It is high for exactly the one cycle after the edge that accepted a word's 4th byte. im_waddr and im_wdata are valid in that same cycle and hold their values afterwards.
- Throughput is one byte per cycle. in_ready stays high during an im_we pulse, because the shift register and im_wdata are separate.
- The last word's im_we pulse occurs in the first cycle of CSUM.
- done, err and cpu_hold update on the edge that accepts the checksum byte, or on the edge where the timeout count is reached.
- Simultaneous transfer and timeout expiry: the transfer wins and the counter clears.
- Asserting rst_n low in any state returns all outputs to their reset values immediately. Any word being assembled is discarded.

## Test plan
- Frame N=2, words 0x2001000A and 0x8C220004, checksum = XOR of all 9 bytes, sent back-to-back:
  - im_we pulses with addr 0 / 0x2001000A, then addr 1 / 0x8C220004.
  - done=1, err=00, cpu_hold falls on the edge that accepts the checksum byte.
- Same frame with checksum byte off by 0x01 -> done=1, err=01, cpu_hold=1.
- Same frame with in_valid deasserted for 3 random cycles between bytes -> identical writes and result; in_ready never deasserts before DONE.
- TIMEOUT=16, stop the stream after 5 data bytes -> word 0 written; DONE exactly 16 idle cycles later with err=10; no write to addr 1.
- N=0, 1024 data bytes -> 256 writes at addresses 0..255 with correct wrap; then a start pulse -> back to CNT, done=0, cpu_hold=1, in_ready=1.
- rst_n pulsed low mid-word (after 2 bytes) -> outputs at reset values. A new N=1 frame then writes its word to addr 0 correctly.
